seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/divider_pkg.sv | 10 +
 rtl/divider_step.sv | 23 ++
 rtl/seq_divider.sv | 135 +++++++++++++
 tb/tb_seq_divider.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types for the sequential divider
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one restoring radix-2 step: shift in a dividend bit, trial-subtract, select
module divider_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             dividend_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // The extra top bit of diff is the borrow; no borrow means the trial fits.
    always_comb begin
        shifted = {rem_i, dividend_bit_i};
        diff    = shifted - {2'b00, divisor_i};
        q_bit_o = ~diff[WIDTH+1];
        rem_o   = q_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, WIDTH cycles per result; DIVIDER_SIGNED_EN adds signed_i
module seq_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
`ifdef DIVIDER_SIGNED_EN
    input  logic             signed_i,
`endif
    output logic             busy_o,
    output logic             finish_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH:0]   rem_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] dd_mag, dv_mag;
    logic [WIDTH-1:0] fin_quo, fin_rem;
    logic             accept, last_step, div_zero;

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_i          (rem_q),
        .dividend_bit_i (quo_q[WIDTH-1]),
        .divisor_i      (divisor_q),
        .rem_o          (rem_next),
        .q_bit_o        (q_bit)
    );

    // The dividend register doubles as the quotient: bits shift out at the top, results in at the bottom.
    assign quo_next  = {quo_q[WIDTH-2:0], q_bit};
    assign rem_mag   = rem_next[WIDTH-1:0];
    assign accept    = (state_q == IDLE) && start_i;
    assign div_zero  = (divisor_i == '0);
    assign last_step = (state_q == CALC) && (cnt_q == CW'(WIDTH - 1));

`ifdef DIVIDER_SIGNED_EN
    logic dd_neg, dv_neg;
    logic quo_neg_q, rem_neg_q;

    always_comb begin
        dd_neg  = signed_i & dividend_i[WIDTH-1];
        dv_neg  = signed_i & divisor_i[WIDTH-1];
        dd_mag  = dd_neg ? -dividend_i : dividend_i;
        dv_mag  = dv_neg ? -divisor_i : divisor_i;
        fin_quo = quo_neg_q ? -quo_next : quo_next;
        fin_rem = rem_neg_q ? -rem_mag : rem_mag;
    end

    // MIN has magnitude 2^(WIDTH-1), which still fits unsigned, so MIN / -1 falls out as MIN.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (accept) begin
            quo_neg_q <= dd_neg ^ dv_neg;
            rem_neg_q <= dd_neg;
        end
    end
`else
    always_comb begin
        dd_mag  = dividend_i;
        dv_mag  = divisor_i;
        fin_quo = quo_next;
        fin_rem = rem_mag;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = div_zero ? DONE : CALC;
            CALC: if (last_step) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            divisor_q   <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                divisor_q <= dv_mag;
                quo_q     <= dd_mag;
                rem_q     <= '0;
                cnt_q     <= '0;
                if (div_zero) begin
                    quotient_o  <= '1;
                    remainder_o <= dividend_i;
                    div_zero_o  <= 1'b1;
                end else begin
                    div_zero_o  <= 1'b0;
                end
            end
            if (state_q == CALC) begin
                rem_q <= rem_next;
                quo_q <= quo_next;
                cnt_q <= cnt_q + CW'(1);
                if (last_step) begin
                    quotient_o  <= fin_quo;
                    remainder_o <= fin_rem;
                end
            end
        end
    end

    assign busy_o   = (state_q == CALC);
    assign finish_o = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider (WIDTH=8)
module tb_seq_divider;

    logic       clk_i;
    logic       reset_i;
    logic       start_i;
    logic [7:0] dividend_i;
    logic [7:0] divisor_i;
    logic       busy_o;
    logic       finish_o;
    logic [7:0] quotient_o;
    logic [7:0] remainder_o;
    logic       div_zero_o;
`ifdef DIVIDER_SIGNED_EN
    logic       signed_sel;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(8)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
`ifdef DIVIDER_SIGNED_EN
        .signed_i    (signed_sel),
`endif
        .busy_o      (busy_o),
        .finish_o    (finish_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .div_zero_o  (div_zero_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at #1 after the accepting edge; lat counts edges from that edge to the finish sample.
    task automatic wait_finish(input int lat0, output int lat, output int nbusy);
        logic seen;
        lat   = lat0;
        nbusy = 0;
        seen  = 1'b0;
        while (!seen && lat < 40) begin
            if (finish_o) begin
                seen = 1'b1;
            end else begin
                nbusy += int'(busy_o);
                @(posedge clk_i); #1;
                lat++;
            end
        end
    endtask

    task automatic do_div(input string tag, input logic [7:0] dd, input logic [7:0] dv,
                          input logic [7:0] eq, input logic [7:0] er, input logic ez);
        int lat, nbusy;
        dividend_i = dd;
        divisor_i  = dv;
        start_i    = 1'b1;
        @(posedge clk_i); #1;
        start_i    = 1'b0;
        dividend_i = 8'h5A;
        divisor_i  = 8'h00;
        wait_finish(1, lat, nbusy);
        check({tag, "_latency"}, lat, (dv == 8'd0) ? 1 : 9);
        check({tag, "_busy_cycles"}, nbusy, (dv == 8'd0) ? 0 : 8);
        check({tag, "_q"}, quotient_o, eq);
        check({tag, "_r"}, remainder_o, er);
        check({tag, "_dz"}, div_zero_o, ez);
        @(posedge clk_i); #1;
        check({tag, "_pulse"}, finish_o, 1'b0);
        check({tag, "_q_hold"}, quotient_o, eq);
    endtask

    initial begin
        int  lat, nbusy;
        logic any_fin;

        reset_i    = 1'b1;
        start_i    = 1'b0;
        dividend_i = 8'd0;
        divisor_i  = 8'd0;
`ifdef DIVIDER_SIGNED_EN
        signed_sel = 1'b0;
`endif
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_finish", finish_o, 1'b0);
        check("rst_q", quotient_o, 8'd0);
        check("rst_r", remainder_o, 8'd0);
        check("rst_dz", div_zero_o, 1'b0);
        reset_i = 1'b0;
        @(posedge clk_i); #1;

        do_div("u100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        do_div("u200_0", 8'd200, 8'd0, 8'hFF, 8'd200, 1'b1);
        do_div("u9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
        do_div("u5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        do_div("u255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        do_div("u255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);

        // start pulsed during CALC and during DONE must be ignored
        dividend_i = 8'd100;
        divisor_i  = 8'd7;
        start_i    = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        start_i    = 1'b1;
        dividend_i = 8'd50;
        divisor_i  = 8'd5;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        wait_finish(3, lat, nbusy);
        check("calc_start_latency", lat, 9);
        check("calc_start_q", quotient_o, 8'd14);
        check("calc_start_r", remainder_o, 8'd2);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("done_start_busy", busy_o, 1'b0);
        @(posedge clk_i); #1;
        check("done_start_idle", busy_o | finish_o, 1'b0);

        // reset in the 3rd CALC cycle aborts the operation
        do_div("pre_abort_dz", 8'd7, 8'd0, 8'hFF, 8'd7, 1'b1);
        dividend_i = 8'd50;
        divisor_i  = 8'd3;
        start_i    = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("abort_in_calc", busy_o, 1'b1);
        reset_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        start_i = 1'b0;
        check("abort_busy", busy_o, 1'b0);
        check("abort_finish", finish_o, 1'b0);
        check("abort_q", quotient_o, 8'd0);
        check("abort_r", remainder_o, 8'd0);
        check("abort_dz", div_zero_o, 1'b0);
        any_fin = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            any_fin |= finish_o | busy_o;
        end
        check("abort_no_finish", any_fin, 1'b0);
        do_div("post_abort", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

`ifdef DIVIDER_SIGNED_EN
        signed_sel = 1'b1;
        do_div("s_m7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0);
        do_div("s_min_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
        do_div("s_7_m2", 8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0);
        do_div("s_m100_m7", 8'h9C, 8'hF9, 8'd14, 8'hFE, 1'b0);
        do_div("s_m5_0", 8'hFB, 8'd0, 8'hFF, 8'hFB, 1'b1);
        signed_sel = 1'b0;
        do_div("s_off_249_2", 8'hF9, 8'd2, 8'd124, 8'd1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
